theta_sweep_source: RTL

THETA_SWEEP_SOURCE -- requirements
Module: theta_sweep_source

---
 rtl/theta_sweep_source_pkg.sv | 28 ++
 rtl/axis_beat_sender.sv | 43 ++++
 rtl/theta_sweep_source.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/theta_sweep_source_pkg.sv
`default_nettype none
// ============================================================================
// Module      : theta_sweep_source_pkg
// Description : Shared constants, sweep FSM state encoding and a clamp helper
//               used by theta_sweep_source and the downstream p_theta stage.
// Revision    : 1.0 - initial release
// ============================================================================
package theta_sweep_source_pkg;

    localparam int MATRIX_SIZE = 4;
    localparam int THETA_COUNT = 19;
    localparam int THETA_W     = $clog2(THETA_COUNT) + 1;

    // Highest legal theta index; a sweep never steps past it.
    localparam logic [THETA_W-1:0] C_THETA_LAST = THETA_W'(THETA_COUNT - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } sweep_state_t;

    // Limit a requested theta index to the legal range.
    function automatic logic [THETA_W-1:0] clamp_theta(input logic [THETA_W-1:0] i_v);
        return (i_v > C_THETA_LAST) ? C_THETA_LAST : i_v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_beat_sender.sv
`default_nettype none
// ============================================================================
// Module      : axis_beat_sender
// Description : Per-channel valid / sent-flag tracker for one AXI-Stream
//               output of the theta sweep. Valid is raised for every beat of
//               an active sweep until the channel has transferred, then held
//               low until the beat completes on all channels.
// Ports       : clk, reset_n      - clock, async active-low reset
//               i_active          - sweep in progress
//               i_tready          - downstream ready of this channel
//               i_beat_done       - beat finished on all channels
//               o_tvalid          - channel valid (registered terms only)
//               o_done            - channel has transferred this beat
// Revision    : 1.0 - initial release
// ============================================================================
module axis_beat_sender (
    input  logic clk,
    input  logic reset_n,
    input  logic i_active,
    input  logic i_tready,
    input  logic i_beat_done,
    output logic o_tvalid,
    output logic o_done
);

    logic r_sent;

    // Valid is built from state and the flag only, never from tready.
    assign o_tvalid = i_active & ~r_sent;
    assign o_done   = r_sent | (o_tvalid & i_tready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sent <= 1'b0;
        end else if (i_beat_done || !i_active) begin
            r_sent <= 1'b0;
        end else if (o_tvalid && i_tready) begin
            r_sent <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/theta_sweep_source.sv
`default_nettype none
// ============================================================================
// Module      : theta_sweep_source
// Description : Accepts one covariance matrix R and emits a sweep of theta
//               beats; each beat presents R on the R channel and the theta
//               index on the theta channel. Channels handshake independently;
//               a beat completes once both have transferred.
// Ports       : clk, reset_n            - clock, async active-low reset
//               s_axis_*                - R input stream (tlast ignored)
//               m_axis_r_*              - R output stream
//               m_axis_theta_*          - theta index stream
//               sweep_busy              - sweep in progress
//               cfg_theta_start/stop    - sweep range (THETA_RANGE_EN only)
// Config      : THETA_RANGE_EN - adds a start/stop theta range sampled when R
//               is accepted; when undefined the sweep is 0..THETA_COUNT-1.
// Revision    : 1.0 - initial release
// ============================================================================
module theta_sweep_source
    import theta_sweep_source_pkg::*;
#(
    parameter int NUM_SIZE = 32
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
`ifdef THETA_RANGE_EN
    input  logic [THETA_W-1:0]                        cfg_theta_start,
    input  logic [THETA_W-1:0]                        cfg_theta_stop,
`endif
    input  logic [MATRIX_SIZE*MATRIX_SIZE*NUM_SIZE-1:0] s_axis_tdata,
    input  logic                                      s_axis_tvalid,
    input  logic                                      s_axis_tlast,
    input  logic                                      s_axis_tuser,
    output logic                                      s_axis_tready,
    output logic [MATRIX_SIZE*MATRIX_SIZE*NUM_SIZE-1:0] m_axis_r_tdata,
    output logic                                      m_axis_r_tvalid,
    output logic                                      m_axis_r_tlast,
    output logic                                      m_axis_r_tuser,
    input  logic                                      m_axis_r_tready,
    output logic [THETA_W-1:0]                        m_axis_theta_tdata,
    output logic                                      m_axis_theta_tvalid,
    output logic                                      m_axis_theta_tlast,
    output logic                                      m_axis_theta_tuser,
    input  logic                                      m_axis_theta_tready,
    output logic                                      sweep_busy
);

    localparam int C_DW = MATRIX_SIZE * MATRIX_SIZE * NUM_SIZE;

    sweep_state_t        r_state;
    sweep_state_t        w_state_nxt;
    logic [C_DW-1:0]     r_rdata;
    logic [THETA_W-1:0]  r_theta;
    logic [THETA_W-1:0]  r_stop;
    logic                r_first;
    logic                r_s_tuser;
    logic                r_alive;

    logic                w_accept;
    logic                w_active;
    logic                w_last;
    logic                w_beat_done;
    logic                w_r_done;
    logic                w_t_done;
    logic [THETA_W-1:0]  w_start_sel;
    logic [THETA_W-1:0]  w_stop_sel;

    // ------------------------------------------------------------------------
    // Sweep range selection, evaluated at the R accept.
    // ------------------------------------------------------------------------
`ifdef THETA_RANGE_EN
    // An inverted range collapses to a single beat at the clamped stop.
    assign w_stop_sel  = clamp_theta(cfg_theta_stop);
    assign w_start_sel = (cfg_theta_start > w_stop_sel) ? w_stop_sel : cfg_theta_start;
`else
    assign w_stop_sel  = C_THETA_LAST;
    assign w_start_sel = '0;
`endif

    // r_alive keeps the input closed while reset is held and for the edge
    // it is released on, so nothing can be accepted during reset.
    assign s_axis_tready = (r_state == ST_IDLE) & r_alive;
    assign w_accept      = s_axis_tready & s_axis_tvalid;
    assign w_active      = (r_state == ST_SWEEP);
    assign w_last        = (r_theta == r_stop);
    assign w_beat_done   = w_active & w_r_done & w_t_done;
    assign sweep_busy    = w_active;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                if (w_beat_done && w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: latched R, theta counter, first-beat marker
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata   <= '0;
            r_theta   <= '0;
            r_stop    <= '0;
            r_first   <= 1'b0;
            r_s_tuser <= 1'b0;
            r_alive   <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (w_accept) begin
                r_rdata   <= s_axis_tdata;
                r_s_tuser <= s_axis_tuser;
                r_theta   <= w_start_sel;
                r_stop    <= w_stop_sel;
                r_first   <= 1'b1;
            end else if (w_beat_done) begin
                r_first <= 1'b0;
                // Counter stops at the last index; the FSM leaves SWEEP instead.
                if (!w_last) begin
                    r_theta <= r_theta + THETA_W'(1);
                end
            end
        end
    end

    // Upstream framing bits carry no meaning for the sweep itself.
    logic w_unused_inputs;
    assign w_unused_inputs = &{1'b0, s_axis_tlast, r_s_tuser};

    // ------------------------------------------------------------------------
    // Output channels
    // ------------------------------------------------------------------------
    axis_beat_sender u_r_sender (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_active    (w_active),
        .i_tready    (m_axis_r_tready),
        .i_beat_done (w_beat_done),
        .o_tvalid    (m_axis_r_tvalid),
        .o_done      (w_r_done)
    );

    axis_beat_sender u_theta_sender (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_active    (w_active),
        .i_tready    (m_axis_theta_tready),
        .i_beat_done (w_beat_done),
        .o_tvalid    (m_axis_theta_tvalid),
        .o_done      (w_t_done)
    );

    assign m_axis_r_tdata     = r_rdata;
    assign m_axis_r_tuser     = w_active & r_first;
    assign m_axis_r_tlast     = w_active & w_last;
    assign m_axis_theta_tdata = r_theta;
    assign m_axis_theta_tuser = w_active & r_first;
    assign m_axis_theta_tlast = w_active & w_last;

endmodule
`default_nettype wire
